// File: rtl/stream_alpha_lifo_if.sv
// Handshake and data bundle between the forward/backward recursions and the
// alpha LIFO. The slave side is the LIFO itself.
interface stream_alpha_lifo_if #(
  parameter int BITS           = 16,
  parameter int STATES         = 4,
  parameter int OUTPUT_SYMBOLS = 4,
  parameter int SYMBOLS        = 10
);
  localparam int IDX_W = $clog2(SYMBOLS);

  logic                                  alpha_valid;
  logic                                  alpha_ready;
  logic [STATES-1:0][BITS-1:0]           AlphaMetric;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]   branch_metric;
  logic                                  beta_valid;
  logic                                  beta_ready;
  logic [STATES-1:0][BITS-1:0]           BetaMetric;
  logic                                  out_valid;
  logic [STATES-1:0][BITS-1:0]           out_AlphaMetric;
  logic [OUTPUT_SYMBOLS-1:0][BITS-1:0]   out_branch_metric;
  logic [STATES-1:0][BITS-1:0]           out_BetaMetric;
  logic [IDX_W-1:0]                      out_index;
  logic                                  out_last;
  logic                                  beta_drop;

  modport master (
    output alpha_valid, AlphaMetric, branch_metric, beta_valid, BetaMetric,
    input  alpha_ready, beta_ready, out_valid, out_AlphaMetric,
           out_branch_metric, out_BetaMetric, out_index, out_last, beta_drop
  );

  modport slave (
    input  alpha_valid, AlphaMetric, branch_metric, beta_valid, BetaMetric,
    output alpha_ready, beta_ready, out_valid, out_AlphaMetric,
           out_branch_metric, out_BetaMetric, out_index, out_last, beta_drop
  );
endinterface

// File: rtl/stream_alpha_lifo.sv
// Stores one frame of alpha/branch metrics in symbol order and replays it in
// reverse, pairing each entry with the incoming beta of the same symbol.
module stream_alpha_lifo #(
  parameter int BITS           = 16,
  parameter int STATES         = 4,
  parameter int OUTPUT_SYMBOLS = 4,
  parameter int SYMBOLS        = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  stream_alpha_lifo_if.slave   bus
);
  localparam int IDX_W  = $clog2(SYMBOLS);
  localparam int A_W    = STATES * BITS;
  localparam int B_W    = OUTPUT_SYMBOLS * BITS;
  localparam int WORD_W = A_W + B_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMBOLS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    wr_ptr, rd_ptr;
  logic                wr_en, rd_en;
  logic                alpha_ready, beta_ready;
  logic [WORD_W-1:0]   mem [SYMBOLS];
  logic [WORD_W-1:0]   rd_word;

  assign bus.alpha_ready = alpha_ready;
  assign bus.beta_ready  = beta_ready;
  assign rd_word         = mem[rd_ptr];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // Next state, strobes and ready decode (ready depends on state only)
  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    alpha_ready = 1'b0;
    beta_ready  = 1'b0;
    case (state)
      FILL: begin
        alpha_ready = 1'b1;
        wr_en       = bus.alpha_valid;
        if (wr_en && wr_ptr == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        beta_ready = 1'b1;
        rd_en      = bus.beta_valid;
        if (rd_en && rd_ptr == '0) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Write/read pointers; each reloads at the end of its own pass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= LAST_IDX;
    end else begin
      if (wr_en) begin
        if (wr_ptr == LAST_IDX) begin
          wr_ptr <= '0;
          rd_ptr <= LAST_IDX;
        end else begin
          wr_ptr <= wr_ptr + IDX_W'(1);
        end
      end
      if (rd_en) begin
        if (rd_ptr == '0) rd_ptr <= LAST_IDX;
        else              rd_ptr <= rd_ptr - IDX_W'(1);
      end
    end
  end

  // Frame storage, not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {bus.AlphaMetric, bus.branch_metric};
  end

  // Aligned output triple and drop pulse, one cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid         <= 1'b0;
      bus.out_last          <= 1'b0;
      bus.beta_drop         <= 1'b0;
      bus.out_AlphaMetric   <= '0;
      bus.out_branch_metric <= '0;
      bus.out_BetaMetric    <= '0;
      bus.out_index         <= '0;
    end else begin
      bus.out_valid <= rd_en;
      bus.out_last  <= rd_en && (rd_ptr == '0);
      bus.beta_drop <= bus.beta_valid && (state == FILL);
      if (rd_en) begin
        bus.out_AlphaMetric   <= rd_word[WORD_W-1:B_W];
        bus.out_branch_metric <= rd_word[B_W-1:0];
        bus.out_BetaMetric    <= bus.BetaMetric;
        bus.out_index         <= rd_ptr;
      end
    end
  end
endmodule

// File: tb/tb_stream_alpha_lifo.sv
// Bench for stream_alpha_lifo: frame-level reference model (arrays + counters)
// predicting every output each cycle under directed and random stimulus.
module tb_stream_alpha_lifo;
  localparam int BITS    = 16;
  localparam int STATES  = 4;
  localparam int OS      = 4;
  localparam int SYMBOLS = 10;

  typedef logic [STATES-1:0][BITS-1:0] avec_t;
  typedef logic [OS-1:0][BITS-1:0]     bvec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stream_alpha_lifo_if #(.BITS(BITS), .STATES(STATES), .OUTPUT_SYMBOLS(OS),
                         .SYMBOLS(SYMBOLS)) bus ();

  stream_alpha_lifo #(.BITS(BITS), .STATES(STATES), .OUTPUT_SYMBOLS(OS),
                      .SYMBOLS(SYMBOLS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned nvalid;

  // reference model
  bit    m_fill;
  int    m_wcnt, m_ridx;
  avec_t m_alpha  [SYMBOLS];
  bvec_t m_branch [SYMBOLS];
  bit    e_valid, e_last, e_drop;
  int    e_idx;
  avec_t e_alpha, e_beta;
  bvec_t e_branch;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic avec_t ra();
    avec_t v;
    for (int i = 0; i < STATES; i++) v[i] = BITS'($urandom);
    return v;
  endfunction

  function automatic bvec_t rb();
    bvec_t v;
    for (int i = 0; i < OS; i++) v[i] = BITS'($urandom);
    return v;
  endfunction

  task automatic model_reset();
    m_fill = 1'b1; m_wcnt = 0; m_ridx = SYMBOLS - 1;
    e_valid = 0; e_last = 0; e_drop = 0; e_idx = 0;
    e_alpha = '0; e_beta = '0; e_branch = '0;
  endtask

  task automatic check_outputs();
    chk("out_valid",  bus.out_valid,         e_valid);
    chk("out_last",   bus.out_last,          e_last);
    chk("beta_drop",  bus.beta_drop,         e_drop);
    chk("out_index",  bus.out_index,         e_idx);
    chk("out_alpha",  bus.out_AlphaMetric,   e_alpha);
    chk("out_branch", bus.out_branch_metric, e_branch);
    chk("out_beta",   bus.out_BetaMetric,    e_beta);
  endtask

  // one clock: drive, advance the model, then sample after the edge
  task automatic cycle(input bit av, input bit bv, input avec_t a, input bvec_t b, input avec_t be);
    bus.alpha_valid   = av;
    bus.AlphaMetric   = a;
    bus.branch_metric = b;
    bus.beta_valid    = bv;
    bus.BetaMetric    = be;
    e_valid = 0; e_last = 0; e_drop = 0;
    if (m_fill) begin
      e_drop = bv;
      if (av) begin
        m_alpha[m_wcnt]  = a;
        m_branch[m_wcnt] = b;
        m_wcnt++;
        if (m_wcnt == SYMBOLS) begin
          m_fill = 0;
          m_ridx = SYMBOLS - 1;
        end
      end
    end else if (bv) begin
      e_valid  = 1;
      e_idx    = m_ridx;
      e_last   = (m_ridx == 0);
      e_alpha  = m_alpha[m_ridx];
      e_branch = m_branch[m_ridx];
      e_beta   = be;
      if (m_ridx == 0) begin
        m_fill = 1;
        m_wcnt = 0;
      end else begin
        m_ridx--;
      end
    end
    @(posedge clk); #1;
    check_outputs();
    chk("alpha_ready", bus.alpha_ready, m_fill);
    chk("beta_ready",  bus.beta_ready,  !m_fill);
    if (bus.out_valid) nvalid++;
  endtask

  task automatic fill(input int k0, input int k1, input bit directed, input int maxgap);
    avec_t a;
    bvec_t b;
    for (int k = k0; k < k1; k++) begin
      repeat ($urandom_range(0, maxgap)) cycle(0, 0, ra(), rb(), ra());
      a = ra(); b = rb();
      if (directed) begin
        for (int s = 0; s < STATES; s++) a[s] = BITS'(16'h0100 + 16 * k + s);
        for (int o = 0; o < OS; o++)     b[o] = BITS'(16'h0200 + 16 * k + o);
      end
      cycle(1, 0, a, b, ra());
    end
  endtask

  // misuse=1 toggles alpha_valid randomly while draining
  task automatic drain(input int count, input bit directed, input int maxgap, input bit misuse);
    avec_t be;
    for (int j = 0; j < count; j++) begin
      repeat ($urandom_range(0, maxgap)) cycle(misuse && $urandom_range(0, 1) == 1, 0, ra(), rb(), ra());
      be = ra();
      if (directed)
        for (int s = 0; s < STATES; s++) be[s] = BITS'(16'h0300 + 16 * j + s);
      cycle(misuse && $urandom_range(0, 1) == 1, 1, ra(), rb(), be);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    chk("rst_alpha_ready", bus.alpha_ready, 1'b1);
    chk("rst_beta_ready",  bus.beta_ready,  1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    bus.alpha_valid = 0; bus.beta_valid = 0;
    bus.AlphaMetric = '0; bus.branch_metric = '0; bus.BetaMetric = '0;
    #1;
    do_reset();

    // directed fill/drain
    fill(0, SYMBOLS, 1, 0);
    nvalid = 0;
    drain(SYMBOLS, 1, 0, 0);
    cycle(0, 0, ra(), rb(), ra());
    chk("nvalid_directed", nvalid, SYMBOLS);

    // gapped random frames, alpha_valid noise during drain
    for (int f = 0; f < 3; f++) begin
      fill(0, SYMBOLS, 0, 3);
      nvalid = 0;
      drain(SYMBOLS, 0, 3, 1);
      chk("nvalid_gapped", nvalid, SYMBOLS);
    end

    // two frames back-to-back, no idle
    for (int f = 0; f < 2; f++) begin
      fill(0, SYMBOLS, 0, 0);
      nvalid = 0;
      drain(SYMBOLS, 0, 0, 0);
      chk("nvalid_b2b", nvalid, SYMBOLS);
    end

    // beta in FILL after three writes, alpha in DRAIN
    fill(0, 3, 0, 0);
    cycle(0, 1, ra(), rb(), ra());
    cycle(0, 0, ra(), rb(), ra());
    fill(3, SYMBOLS, 0, 1);
    nvalid = 0;
    drain(SYMBOLS, 0, 2, 1);
    chk("nvalid_misuse", nvalid, SYMBOLS);

    // reset mid-drain, then a clean frame
    fill(0, SYMBOLS, 0, 0);
    drain(4, 0, 1, 0);
    do_reset();
    fill(0, SYMBOLS, 0, 1);
    nvalid = 0;
    drain(SYMBOLS, 0, 1, 0);
    chk("nvalid_after_rst", nvalid, SYMBOLS);
    cycle(0, 0, ra(), rb(), ra());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/stream_alpha_lifo.md
Name: stream_alpha_lifo

Overview:
- Upstream alignment stage for stream_max_product.
- The forward recursion produces alpha and branch metrics in symbol order 0..SYMBOLS-1. The backward recursion produces beta metrics in order SYMBOLS-1..0.
- This block stores one frame of alpha and branch metrics and replays them in reverse. Each replayed entry is paired with the incoming beta of the same symbol index.
- Outputs drive in_valid, AlphaMetric, branch_metric and BetaMetric of stream_max_product directly. No arithmetic is performed; PRECISION is irrelevant here.

Parameters:
- BITS, 16, width of every metric word.
- STATES, 4, number of trellis states (alpha and beta vector length).
- OUTPUT_SYMBOLS, 4, branch metric vector length.
- SYMBOLS, 10, frame length in symbols (>=2).

Ports:
- clk  input  1  clock.
- rst  input  1  reset; one clock, reset is asynchronous and active-high.
- alpha_valid  input  1  alpha/branch write strobe.
- alpha_ready  output  1  block accepts alpha/branch this cycle.
- AlphaMetric  input  BITS x STATES  forward metrics for the current symbol.
- branch_metric  input  BITS x OUTPUT_SYMBOLS  branch metrics for the current symbol.
- beta_valid  input  1  beta strobe.
- beta_ready  output  1  block accepts beta this cycle.
- BetaMetric  input  BITS x STATES  backward metrics for the current symbol.
- out_valid  output  1  aligned triple valid.
- out_AlphaMetric  output  BITS x STATES  replayed alpha.
- out_branch_metric  output  BITS x OUTPUT_SYMBOLS  replayed branch metrics.
- out_BetaMetric  output  BITS x STATES  registered beta.
- out_index  output  $clog2(SYMBOLS)  symbol index of the output triple.
- out_last  output  1  high with the triple for index 0 (end of frame).
- beta_drop  output  1  one-cycle pulse when beta_valid arrives while beta_ready=0.

Behaviour:
- Storage: SYMBOLS-deep memory, word = (STATES+OUTPUT_SYMBOLS)*BITS. Memory contents are not reset.
- Pointers:
  - wr_ptr counts 0..SYMBOLS-1.
  - rd_ptr counts SYMBOLS-1..0.
  - Neither pointer wraps mid-frame; both reload at the FSM transitions below.
- FSM with two states, FILL and DRAIN. Reset state is FILL with wr_ptr=0.
- FILL:
  - alpha_ready=1, beta_ready=0.
  - On alpha_valid: write {AlphaMetric, branch_metric} at wr_ptr, then wr_ptr++.
  - On the write at wr_ptr=SYMBOLS-1: next state DRAIN, rd_ptr=SYMBOLS-1, wr_ptr=0.
- DRAIN:
  - alpha_ready=0, beta_ready=1. Alpha input is ignored (no write, no error).
  - On beta_valid: read the word at rd_ptr and register it with BetaMetric, then rd_ptr--.
  - On the read at rd_ptr=0: next state FILL.
- Output latency is exactly 1 cycle from an accepted beta.
  - out_valid=1 with out_index equal to the rd_ptr used.
  - out_last=1 only when out_index=0.
  - out_valid deasserts the next cycle unless another beta is accepted. Back-to-back betas give back-to-back outputs at full rate.
- Transition cycles:
  - The cycle after the last alpha write, beta_ready is already 1. The FILL->DRAIN turnaround has no bubble.
  - The cycle after the last beta read, alpha_ready=1. The DRAIN->FILL turnaround has no bubble.
  - The final output (out_last) and the first write of the next frame may occur in the same cycle with no conflict.
- beta_drop: registered pulse one cycle after beta_valid=1 while in FILL. The beta is discarded and no state changes.
- Reset (any time, including mid-frame): state FILL, both pointers reloaded.
  - out_valid, out_last, beta_drop = 0.
  - out_AlphaMetric, out_branch_metric, out_BetaMetric, out_index = 0.
  - A partial frame is abandoned. The next alpha is written at index 0.
- alpha_ready and beta_ready are decoded from state only. They never depend combinationally on the valid inputs.

Test Plan:
- Fill/drain, SYMBOLS=10, STATES=4, OUTPUT_SYMBOLS=4, BITS=16:
  - Stimulus: write alpha[k][s]=16'h0100+16*k+s and branch[k][o]=16'h0200+16*k+o for k=0..9 back-to-back. Then apply 10 betas with beta[s]=16'h0300+16*j+s, j=0..9.
  - Required: 10 consecutive out_valid cycles, out_index 9..0, and out_AlphaMetric[0] = 16'h0190, 16'h0180, ... 16'h0100. out_BetaMetric matches beta j registered one cycle later. out_last is high only with index 0.
- Gapped streams: insert random 0-3 cycle gaps on alpha_valid and beta_valid.
  - Required: identical data and ordering to the fill/drain case. out_valid count is 10 per frame.
- Two frames back-to-back with no idle:
  - Required: alpha_ready rises the cycle after the 10th beta is accepted. Frame-2 data is replayed reversed with no corruption from frame 1.
- Protocol misuse:
  - Stimulus: beta_valid=1 in FILL after 3 alpha writes.
  - Required: beta_drop pulses, no out_valid, and wr_ptr continues at 3.
  - Stimulus: alpha_valid=1 in DRAIN.
  - Required: the stored frame is unchanged.
- Reset mid-DRAIN: assert rst after 4 betas have been consumed.
  - Required: all outputs are 0 immediately (async), and alpha_ready=1 after release.
  - A full new frame then replays correctly starting at out_index 9.
